spi_adc_sampler: RTL and testbench

Drives an external 8-channel, 10-bit SPI ADC and presents the results on the design's sample-stream interface (`channel` request in; `new_sample`/`sample`/`sample_channel` out). It sits between the ADC pins and consumer blocks such as the servo and LED controllers. It converts the channel the consumer requests, back-to-back and continuously, and emits one valid pulse per completed conversion.

---
 rtl/spi_adc_sampler.sv | 133 +++++++++++++
 tb/tb_spi_adc_sampler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_sampler.sv
// Continuous sampler for an 8-channel, 10-bit SPI ADC (mode 0).
// Each frame is 17 SCK periods. The result is emitted as a one-cycle new_sample pulse.
module spi_adc_sampler #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] channel,
    output logic       new_sample,
    output logic [9:0] sample,
    output logic [3:0] sample_channel,
    output logic       adc_cs_n,
    output logic       adc_sck,
    output logic       adc_mosi,
    input  logic       adc_miso
);

    localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       period;
    logic [2:0]       frame_ch;
    logic [9:0]       shift;

    // Command bit sent during SCK period k: start, single-ended, channel MSB first.
    function automatic logic mosi_bit(input logic [4:0] k, input logic [2:0] ch);
        case (k)
            5'd0, 5'd1: mosi_bit = 1'b1;
            5'd2:       mosi_bit = ch[2];
            5'd3:       mosi_bit = ch[1];
            5'd4:       mosi_bit = ch[0];
            default:    mosi_bit = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            period         <= '0;
            frame_ch       <= '0;
            shift          <= '0;
            adc_cs_n       <= 1'b1;
            adc_sck        <= 1'b0;
            adc_mosi       <= 1'b0;
            new_sample     <= 1'b0;
            sample         <= '0;
            sample_channel <= '0;
        end else begin
            new_sample <= 1'b0;
            case (state)
                IDLE: begin
                    if (!channel[3]) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                        adc_mosi <= 1'b1;
                        frame_ch <= channel[2:0];
                        period   <= '0;
                        cnt      <= CNT_W'(CLK_DIV - 1);
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state   <= HIGH;
                        adc_sck <= 1'b1;
                        cnt     <= CNT_W'(CLK_DIV - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    // Sample on the first cycle SCK is high; the 10 data bits end up last.
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        shift <= {shift[8:0], adc_miso};
                    end
                    if (cnt == '0) begin
                        state    <= LOW;
                        adc_sck  <= 1'b0;
                        adc_mosi <= mosi_bit(period + 5'd1, frame_ch);
                        cnt      <= CNT_W'(CLK_DIV - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == '0) begin
                        if (period == 5'd16) begin
                            state          <= GAP;
                            adc_cs_n       <= 1'b1;
                            adc_mosi       <= 1'b0;
                            new_sample     <= 1'b1;
                            sample         <= shift;
                            sample_channel <= {1'b0, frame_ch};
                            cnt            <= CNT_W'(GAP_CYCLES - 1);
                        end else begin
                            state   <= HIGH;
                            adc_sck <= 1'b1;
                            period  <= period + 5'd1;
                            cnt     <= CNT_W'(CLK_DIV - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    // The last gap cycle doubles as the IDLE evaluation so back-to-back
                    // frames keep CS high for exactly GAP_CYCLES.
                    if (cnt == '0) begin
                        if (!channel[3]) begin
                            state    <= SETUP;
                            adc_cs_n <= 1'b0;
                            adc_mosi <= 1'b1;
                            frame_ch <= channel[2:0];
                            period   <= '0;
                            cnt      <= CNT_W'(CLK_DIV - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Bench for spi_adc_sampler: behavioural ADC model plus a scoreboard of expected pulses.
// Instance 0 uses default parameters. Instance 1 uses CLK_DIV=2 and GAP_CYCLES=1.
module tb_spi_adc_sampler;

    logic       clk;
    logic       rst;
    logic [3:0] ch0, ch1;
    logic [1:0] ns, cs_n, sck, mosi, miso;
    logic [9:0] smp [2];
    logic [3:0] sch [2];

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int fails = 0;

    logic [9:0]  data_q0 [$];
    logic [9:0]  data_q1 [$];
    logic [2:0]  mosi_q0 [$];
    logic [2:0]  mosi_q1 [$];
    logic [13:0] exp_q0  [$];
    logic [13:0] exp_q1  [$];

    int pulse_count [2] = '{0, 0};
    int last_pulse  [2] = '{0, 0};
    logic prev_ns   [2] = '{1'b0, 1'b0};

    int         falls    [2];
    logic       loaded   [2];
    logic       prev_sck [2];
    logic [9:0] data     [2];
    logic [4:0] cmd      [2];

    spi_adc_sampler u_dut0 (
        .clk(clk), .rst(rst), .channel(ch0),
        .new_sample(ns[0]), .sample(smp[0]), .sample_channel(sch[0]),
        .adc_cs_n(cs_n[0]), .adc_sck(sck[0]), .adc_mosi(mosi[0]), .adc_miso(miso[0])
    );

    spi_adc_sampler #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .channel(ch1),
        .new_sample(ns[1]), .sample(smp[1]), .sample_channel(sch[1]),
        .adc_cs_n(cs_n[1]), .adc_sck(sck[1]), .adc_mosi(mosi[1]), .adc_miso(miso[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ADC model: shifts data out on SCK falling edges and collects command bits on rising edges.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_n[i] !== 1'b0) begin
                falls[i]    = 0;
                loaded[i]   = 1'b0;
                prev_sck[i] = 1'b0;
                miso[i]     = 1'b0;
            end else begin
                if (!loaded[i]) begin
                    loaded[i] = 1'b1;
                    cmd[i]    = '0;
                    if (i == 0) data[i] = (data_q0.size() > 0) ? data_q0.pop_front() : 10'h0;
                    else        data[i] = (data_q1.size() > 0) ? data_q1.pop_front() : 10'h0;
                end
                if (sck[i] && !prev_sck[i] && falls[i] < 5) cmd[i] = {cmd[i][3:0], mosi[i]};
                if (!sck[i] && prev_sck[i]) begin
                    falls[i]++;
                    if (falls[i] == 5) begin
                        logic [2:0] ech;
                        int qs;
                        qs = (i == 0) ? mosi_q0.size() : mosi_q1.size();
                        if (qs == 0) check("mosi_queue_nonempty", 32'(qs), 32'd1);
                        else begin
                            ech = (i == 0) ? mosi_q0.pop_front() : mosi_q1.pop_front();
                            check("mosi_command", 32'(cmd[i]), 32'({2'b11, ech}));
                        end
                    end
                end
                if (falls[i] >= 7 && falls[i] <= 16) begin
                    int bi;
                    bi = 16 - falls[i];
                    miso[i] = data[i][bi[3:0]];
                end else begin
                    miso[i] = 1'b0;
                end
                prev_sck[i] = sck[i];
            end
        end
    end

    // Scoreboard: each pulse pops one expected {channel, sample}.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ns[i] === 1'b1) begin
                logic [13:0] e;
                int qs;
                pulse_count[i]++;
                last_pulse[i] = cyc;
                check("pulse_not_consecutive", 32'(prev_ns[i]), 32'd0);
                qs = (i == 0) ? exp_q0.size() : exp_q1.size();
                if (qs == 0) check("unexpected_pulse", 32'(qs), 32'd1);
                else begin
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check("sample_value", 32'(smp[i]), 32'(e[9:0]));
                    check("sample_channel", 32'(sch[i]), 32'(e[13:10]));
                end
            end
            prev_ns[i] = ns[i];
        end
    end

    task automatic wait_cs_low(input int i, input string tag, output int t);
        logic got;
        got = 1'b0;
        t = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (cs_n[i] === 1'b0) begin
                got = 1'b1;
                t = cyc;
                break;
            end
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_pulse(input int i, input string tag, output int t);
        int pc;
        logic got;
        pc = pulse_count[i];
        got = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            if (pulse_count[i] != pc) begin
                got = 1'b1;
                break;
            end
        end
        t = last_pulse[i];
        check(tag, 32'(got), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int t0, p1, p2, p3, pc0;
        logic saw_cs, saw_ns;

        rst = 1'b1;
        ch0 = 4'd0;
        ch1 = 4'd8;

        // Reset, then a single channel-0 frame
        data_q0.push_back(10'h2A5); mosi_q0.push_back(3'd0); exp_q0.push_back({4'd0, 10'h2A5});
        repeat (3) @(negedge clk);
        check("reset_ctrl0", 32'({cs_n[0], sck[0], mosi[0], ns[0]}), 32'b1000);
        check("reset_data0", 32'({sch[0], smp[0]}), 32'd0);
        @(negedge clk);
        check("reset_ctrl1", 32'({cs_n[1], sck[1], mosi[1], ns[1]}), 32'b1000);
        check("reset_data1", 32'({sch[1], smp[1]}), 32'd0);
        rst = 1'b0;
        wait_cs_low(0, "t1_frame_start", t0);
        ch0 = 4'd8;
        wait_pulse(0, "t1_pulse", p1);
        check("t1_latency", 32'(p1 - t0), 32'd140);

        // Continuous conversion on channel 5
        data_q0.push_back(10'h3FF); data_q0.push_back(10'h000); data_q0.push_back(10'h155);
        repeat (3) mosi_q0.push_back(3'd5);
        exp_q0.push_back({4'd5, 10'h3FF}); exp_q0.push_back({4'd5, 10'h000});
        exp_q0.push_back({4'd5, 10'h155});
        ch0 = 4'd5;
        wait_cs_low(0, "t2_frame_start", t0);
        wait_pulse(0, "t2_pulse1", p1);
        wait_pulse(0, "t2_pulse2", p2);
        wait_cs_low(0, "t2_frame3_start", t0);
        ch0 = 4'd8;
        wait_pulse(0, "t2_pulse3", p3);
        check("t2_period_a", 32'(p2 - p1), 32'd148);
        check("t2_period_b", 32'(p3 - p2), 32'd148);

        // Channel change in the middle of a frame
        data_q0.push_back(10'h0AB); mosi_q0.push_back(3'd2); exp_q0.push_back({4'd2, 10'h0AB});
        data_q0.push_back(10'h1C3); mosi_q0.push_back(3'd6); exp_q0.push_back({4'd6, 10'h1C3});
        ch0 = 4'd2;
        wait_cs_low(0, "t3_frame_start", t0);
        repeat (50) @(negedge clk);
        ch0 = 4'd6;
        wait_pulse(0, "t3_pulse1", p1);
        check("t3_latency", 32'(p1 - t0), 32'd140);
        wait_cs_low(0, "t3_frame2_start", t0);
        ch0 = 4'd8;
        wait_pulse(0, "t3_pulse2", p2);

        // Invalid channel held, then a valid one
        ch0 = 4'd9;
        pc0 = pulse_count[0];
        saw_cs = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cs_n[0] !== 1'b1) saw_cs = 1'b1;
        end
        check("t4_cs_stays_high", 32'(saw_cs), 32'd0);
        check("t4_no_pulse", 32'(pulse_count[0] - pc0), 32'd0);
        data_q0.push_back(10'h2D2); mosi_q0.push_back(3'd1); exp_q0.push_back({4'd1, 10'h2D2});
        ch0 = 4'd1;
        @(negedge clk);
        check("t4_start_next_cycle", 32'(cs_n[0]), 32'd0);
        t0 = cyc;
        ch0 = 4'd8;
        wait_pulse(0, "t4_pulse", p1);
        check("t4_latency", 32'(p1 - t0), 32'd140);

        // Reset in the middle of a frame
        data_q0.push_back(10'h111); mosi_q0.push_back(3'd3);
        data_q0.push_back(10'h0CC); mosi_q0.push_back(3'd3); exp_q0.push_back({4'd3, 10'h0CC});
        ch0 = 4'd3;
        wait_cs_low(0, "t5_frame_start", t0);
        pc0 = pulse_count[0];
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_reset_ctrl", 32'({cs_n[0], sck[0], mosi[0], ns[0]}), 32'b1000);
        check("t5_reset_data", 32'({sch[0], smp[0]}), 32'd0);
        wait_cs_low(0, "t5_restart", t0);
        ch0 = 4'd8;
        saw_ns = 1'b0;
        wait_pulse(0, "t5_pulse", p1);
        check("t5_single_pulse", 32'(pulse_count[0] - pc0), 32'd1);
        check("t5_latency", 32'(p1 - t0), 32'd140);

        // Fast parameter set on instance 1
        data_q1.push_back(10'h203); mosi_q1.push_back(3'd4); exp_q1.push_back({4'd4, 10'h203});
        data_q1.push_back(10'h1C8); mosi_q1.push_back(3'd4); exp_q1.push_back({4'd4, 10'h1C8});
        ch1 = 4'd4;
        wait_cs_low(1, "t6_frame_start", t0);
        wait_pulse(1, "t6_pulse1", p1);
        check("t6_latency", 32'(p1 - t0), 32'd70);
        wait_cs_low(1, "t6_frame2_start", t0);
        ch1 = 4'd8;
        wait_pulse(1, "t6_pulse2", p2);
        check("t6_period", 32'(p2 - p1), 32'd71);

        repeat (20) @(negedge clk);
        check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
